// File: rtl/scan_sequencer.sv
// Scan sequencer: walks the enabled slots of an 8-bit mask, holding the decoder enable for a
// programmable dwell per slot with a one-cycle blank between slots (break-before-make).
`timescale 1ns/1ps
module scan_sequencer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         a,
  output logic               en,
  output logic               busy,
  output logic               slot_done,
  output logic               sweep_done
);

  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

  state_t             state_q, state_d;
  logic [2:0]         a_q, a_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic [7:0]         above;
  logic [DWELL_W-1:0] dwell_eff;
  logic               last, one_hot, end_sweep;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // Bits of the live mask strictly above the current slot; empty means the sweep wraps.
  assign above     = mask & ~((8'd2 << a_q) - 8'd1);
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign last      = (state_q == DWELL) && (cnt_q <= DWELL_W'(1));
  assign one_hot   = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);
  assign end_sweep = (above == 8'd0) || one_hot;

  assign a          = a_q;
  assign en         = (state_q == DWELL);
  assign busy       = (state_q != IDLE);
  assign slot_done  = last && !stop;
  assign sweep_done = slot_done && (mask != 8'd0) && end_sweep;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (mask != 8'd0)) begin
            state_d = DWELL;
            a_d     = lowest_bit(mask);
            cnt_d   = dwell_eff;
          end
        end
        DWELL: begin
          if (!last) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if ((mask == 8'd0) || (end_sweep && mode)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = BLANK;
            a_d     = (above != 8'd0) ? lowest_bit(above) : lowest_bit(mask);
            cnt_d   = '0;
          end
        end
        BLANK: begin
          state_d = DWELL;
          cnt_d   = dwell_eff;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: slot-level reference model checked every cycle, plus literal trace checks.
`timescale 1ns/1ps
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, mode;
  logic [7:0]  mask;
  logic [15:0] dwell;
  logic [2:0]  a;
  logic        en, busy, slot_done, sweep_done;

  int checks = 0;
  int failures = 0;

  bit m_active, m_blank;
  int m_slot, m_left;

  logic [2:0] slot_log[$];
  logic [2:0] sweep_log[$];
  int busy_cnt;

  scan_sequencer #(.DWELL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .mask(mask), .dwell(dwell), .a(a), .en(en), .busy(busy),
    .slot_done(slot_done), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int low_of(input int m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int bits_above(input int m, input int s);
    return m & ~((2 << s) - 1);
  endfunction

  // Reference: per cycle, derive outputs from the slot being scanned and how much dwell is left.
  always begin
    logic e_en, e_sd, e_sw;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      m_active = 0; m_blank = 0; m_slot = 0; m_left = 0;
    end
    e_en = m_active && !m_blank;
    e_sd = e_en && (m_left == 1) && !stop;
    e_sw = e_sd && (mask != 0) &&
           ((bits_above(int'(mask), m_slot) == 0) || ($countones(mask) == 1));
    check("cycle_outputs", {25'd0, busy, en, a, slot_done, sweep_done},
          {25'd0, m_active, e_en, 3'(m_slot), e_sd, e_sw});
    if (slot_done) slot_log.push_back(a);
    if (sweep_done) sweep_log.push_back(a);
    if (busy) busy_cnt++;
    if (rst_n) begin
      if (stop) begin
        m_active = 0;
      end else if (!m_active) begin
        if (start && mask != 0) begin
          m_active = 1; m_blank = 0;
          m_slot = low_of(int'(mask));
          m_left = (dwell == 0) ? 1 : int'(dwell);
        end
      end else if (m_blank) begin
        m_blank = 0;
        m_left = (dwell == 0) ? 1 : int'(dwell);
      end else if (m_left > 1) begin
        m_left--;
      end else if (mask == 0) begin
        m_active = 0;
      end else if (e_sw && mode) begin
        m_active = 0;
      end else begin
        m_blank = 1;
        m_slot = (bits_above(int'(mask), m_slot) != 0) ?
                 low_of(bits_above(int'(mask), m_slot)) : low_of(int'(mask));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] m, input logic [15:0] d, input logic md);
    slot_log.delete();
    sweep_log.delete();
    busy_cnt = 0;
    mask = m; dwell = d; mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 8'h00; dwell = 16'd0;
    busy_cnt = 0;
    cyc(1);
    #1;
    check("reset_a", {29'd0, a}, 32'd0);
    check("reset_en_busy", {30'd0, en, busy}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Single sweep over all slots
    do_start(8'hFF, 16'd2, 1'b1);
    cyc(28);
    check("sweep_busy_cycles", busy_cnt, 23);
    check("sweep_slot_count", slot_log.size(), 8);
    for (int i = 0; i < 8 && i < slot_log.size(); i++) check("sweep_slot_order", {29'd0, slot_log[i]}, i);
    check("sweep_done_count", sweep_log.size(), 1);
    if (sweep_log.size() > 0) check("sweep_done_slot", {29'd0, sweep_log[0]}, 7);

    // Sparse continuous scan
    do_start(8'b1010_0100, 16'd1, 1'b0);
    cyc(18);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    begin
      logic [2:0] exp_seq [6];
      exp_seq = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7};
      check("sparse_slot_count", slot_log.size(), 9);
      for (int i = 0; i < 6 && i < slot_log.size(); i++) check("sparse_slot_order", {29'd0, slot_log[i]}, {29'd0, exp_seq[i]});
    end
    check("sparse_sweep_count", sweep_log.size(), 3);
    foreach (sweep_log[i]) check("sparse_sweep_slot", {29'd0, sweep_log[i]}, 7);

    // Dwell zero on a single-slot mask
    do_start(8'h10, 16'd0, 1'b0);
    cyc(7);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("single_slot_count", slot_log.size(), 4);
    check("single_sweep_count", sweep_log.size(), 4);
    if (slot_log.size() > 0) check("single_slot_a", {29'd0, slot_log[0]}, 4);

    // Stop on the 2nd dwell cycle; a start while busy is ignored
    do_start(8'hFF, 16'd5, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    #1;
    check("stop_en_busy", {30'd0, en, busy}, 32'd0);
    check("stop_a_held", {29'd0, a}, 32'd0);
    check("stop_no_pulses", slot_log.size() + sweep_log.size(), 0);

    // Stop in the last dwell cycle suppresses the pulses
    do_start(8'h08, 16'd1, 1'b0);
    stop = 1'b1;
    #1;
    check("stop_last_pulses", {30'd0, slot_done, sweep_done}, 32'd0);
    cyc(1);
    stop = 1'b0;
    #1;
    check("stop_last_idle_a", {28'd0, busy, a}, 32'd3);

    // Start with an empty mask, then start together with stop
    mask = 8'h00; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    check("empty_mask_busy", {31'd0, busy}, 32'd0);
    mask = 8'hFF; start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    cyc(2);
    check("start_stop_busy", {31'd0, busy}, 32'd0);

    // Mask cleared mid-dwell
    do_start(8'hFF, 16'd3, 1'b0);
    cyc(1);
    mask = 8'h00;
    cyc(4);
    check("live_mask_slots", slot_log.size(), 1);
    check("live_mask_sweeps", sweep_log.size(), 0);
    check("live_mask_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset while dwelling on slot 1
    do_start(8'hFF, 16'd4, 1'b0);
    cyc(5);
    #1;
    check("pre_reset_a_en", {28'd0, en, a}, 32'h9);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_a", {29'd0, a}, 32'd0);
    check("async_reset_en_busy", {30'd0, en, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    check("post_reset_idle", {31'd0, busy}, 32'd0);
    do_start(8'hFF, 16'd4, 1'b0);
    #1;
    check("restart_a_en", {28'd0, en, a}, 32'h8);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
